timer_ip: RTL and testbench

- Memory-mapped machine timer. It is a bus responder on the same peripheral bus the RV32I core drives for uart_ip.
- The core's Device_select region decode gates `wen` and `ren`. The block sees `{4'h0, mem_addr[27:0]}` offsets.
- Provides a 64-bit free-running counter with a prescaler, a 64-bit compare, a sticky match flag and a level interrupt for the core.

---
 rtl/timer_ip.sv | 159 +++++++++++++++
 tb/tb_timer_ip.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ip.sv
// Memory-mapped 64-bit machine timer: prescaled free-running counter, 64-bit compare,
// sticky match flag and level interrupt, on a simple wen/ren peripheral bus.
module timer_ip #(
   parameter logic [15:0] PRESCALE_RST    = 16'd0,
   parameter logic [63:0] CMP_RST         = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter logic        AUTO_RELOAD_RST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   input  logic        wen,
   input  logic [3:0]  wstrb,
   output logic        wready,
   input  logic [31:0] raddr,
   input  logic        ren,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        irq
);
   localparam logic [2:0] A_CTRL     = 3'd0;
   localparam logic [2:0] A_PRESCALE = 3'd1;
   localparam logic [2:0] A_MTIME_LO = 3'd2;
   localparam logic [2:0] A_MTIME_HI = 3'd3;
   localparam logic [2:0] A_CMP_LO   = 3'd4;
   localparam logic [2:0] A_CMP_HI   = 3'd5;
   localparam logic [2:0] A_STATUS   = 3'd6;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   logic        en_r, reload_r, ie_r, match_r;
   logic [15:0] prescale_r, pcnt_r;
   logic [63:0] mtime_r, cmp_r;
   logic [31:0] shadow_hi_r, rdata_r;
   logic        wready_r, rvalid_r, irq_r;

   logic [2:0]  wsel_s, rsel_s, ctrl_nxt_s;
   logic        tick_s, ge_s, clr_s, ps_wr_s, mtime_wr_s, match_nxt_s;
   logic [15:0] prescale_nxt_s, pcnt_nxt_s;
   logic [63:0] mtime_nxt_s, cmp_nxt_s;
   logic [31:0] ctrl_wr_s, prescale_wr_s, rd_mux_s;
   logic        unused_s;

   assign wsel_s        = waddr[4:2];
   assign rsel_s        = raddr[4:2];
   assign ctrl_wr_s     = merge_bytes({29'd0, ie_r, reload_r, en_r}, wdata, wstrb);
   assign prescale_wr_s = merge_bytes({16'd0, prescale_r}, wdata, wstrb);
   assign ps_wr_s       = wen & (wsel_s == A_PRESCALE);
   assign mtime_wr_s    = wen & ((wsel_s == A_MTIME_LO) | (wsel_s == A_MTIME_HI));
   assign clr_s         = wen & (wsel_s == A_STATUS) & wstrb[0] & wdata[0];
   assign tick_s        = en_r & (pcnt_r == prescale_r);
   assign ge_s          = (mtime_r >= cmp_r);
   // A fresh match on this edge beats a simultaneous W1C.
   assign match_nxt_s   = (tick_s & ge_s) | (match_r & ~clr_s);
   assign pcnt_nxt_s    = (ps_wr_s | ~en_r | tick_s) ? 16'd0 : pcnt_r + 16'd1;
   assign unused_s      = ^{waddr[31:5], waddr[1:0], raddr[31:5], raddr[1:0],
                            ctrl_wr_s[31:3], prescale_wr_s[31:16]};

   // Next-state for the bus-writable configuration registers.
   always_comb begin
      ctrl_nxt_s     = {ie_r, reload_r, en_r};
      prescale_nxt_s = prescale_r;
      cmp_nxt_s      = cmp_r;
      if (wen) begin
         case (wsel_s)
            A_CTRL:     ctrl_nxt_s       = ctrl_wr_s[2:0];
            A_PRESCALE: prescale_nxt_s   = prescale_wr_s[15:0];
            A_CMP_LO:   cmp_nxt_s[31:0]  = merge_bytes(cmp_r[31:0], wdata, wstrb);
            A_CMP_HI:   cmp_nxt_s[63:32] = merge_bytes(cmp_r[63:32], wdata, wstrb);
            default:    ctrl_nxt_s       = {ie_r, reload_r, en_r};
         endcase
      end else begin
         ctrl_nxt_s = {ie_r, reload_r, en_r};
      end
   end

   // Counter next-state: a bus write to either half blocks the increment for all 64 bits.
   always_comb begin
      mtime_nxt_s = mtime_r;
      if (mtime_wr_s) begin
         if (wsel_s == A_MTIME_HI) begin
            mtime_nxt_s[63:32] = merge_bytes(mtime_r[63:32], wdata, wstrb);
         end else begin
            mtime_nxt_s[31:0] = merge_bytes(mtime_r[31:0], wdata, wstrb);
         end
      end else if (tick_s) begin
         if (reload_r && ge_s) begin
            mtime_nxt_s = 64'd0;
         end else begin
            mtime_nxt_s = mtime_r + 64'd1;
         end
      end else begin
         mtime_nxt_s = mtime_r;
      end
   end

   // Read data mux; MTIME_HI returns the snapshot taken by the last MTIME_LO read.
   always_comb begin
      rd_mux_s = 32'd0;
      case (rsel_s)
         A_CTRL:     rd_mux_s = {29'd0, ie_r, reload_r, en_r};
         A_PRESCALE: rd_mux_s = {16'd0, prescale_r};
         A_MTIME_LO: rd_mux_s = mtime_r[31:0];
         A_MTIME_HI: rd_mux_s = shadow_hi_r;
         A_CMP_LO:   rd_mux_s = cmp_r[31:0];
         A_CMP_HI:   rd_mux_s = cmp_r[63:32];
         A_STATUS:   rd_mux_s = {31'd0, match_r};
         default:    rd_mux_s = 32'd0;
      endcase
   end

   // State and registered bus outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_r        <= 1'b0;
         reload_r    <= AUTO_RELOAD_RST;
         ie_r        <= 1'b0;
         prescale_r  <= PRESCALE_RST;
         pcnt_r      <= 16'd0;
         mtime_r     <= 64'd0;
         cmp_r       <= CMP_RST;
         match_r     <= 1'b0;
         shadow_hi_r <= 32'd0;
         wready_r    <= 1'b0;
         rvalid_r    <= 1'b0;
         rdata_r     <= 32'd0;
         irq_r       <= 1'b0;
      end else begin
         {ie_r, reload_r, en_r} <= ctrl_nxt_s;
         prescale_r  <= prescale_nxt_s;
         pcnt_r      <= pcnt_nxt_s;
         mtime_r     <= mtime_nxt_s;
         cmp_r       <= cmp_nxt_s;
         match_r     <= match_nxt_s;
         wready_r    <= wen;
         rvalid_r    <= ren;
         irq_r       <= match_r & ie_r;
         if (ren) begin
            rdata_r <= rd_mux_s;
         end
         if (ren && (rsel_s == A_MTIME_LO)) begin
            shadow_hi_r <= mtime_r[63:32];
         end
      end
   end

   assign wready = wready_r;
   assign rvalid = rvalid_r;
   assign rdata  = rdata_r;
   assign irq    = irq_r;
endmodule

// File: tb/tb_timer_ip.sv
// Randomized and directed bench for timer_ip against a cycle-level behavioural model.
module tb_timer_ip;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] waddr = 32'd0, wdata = 32'd0, raddr = 32'd0;
   logic        wen = 1'b0, ren = 1'b0;
   logic [3:0]  wstrb = 4'd0;
   logic        wready, rvalid, irq;
   logic [31:0] rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   timer_ip dut (
      .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
      .wready(wready), .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid), .irq(irq)
   );

   // Behavioural model state
   logic        m_en, m_reload, m_ie, m_match, m_irq, m_rvalid, m_wready;
   logic [15:0] m_pre;
   int unsigned m_pcnt;
   logic [63:0] m_mtime, m_cmp;
   logic [31:0] m_shadow, m_rdata;

   task automatic model_reset();
      m_en = 1'b0; m_reload = 1'b0; m_ie = 1'b0; m_match = 1'b0; m_irq = 1'b0;
      m_rvalid = 1'b0; m_wready = 1'b0; m_pre = 16'd0; m_pcnt = 0;
      m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 32'd0; m_rdata = 32'd0;
   endtask

   function automatic logic [31:0] mreg(input logic [2:0] s);
      case (s)
         3'd0: return {29'd0, m_ie, m_reload, m_en};
         3'd1: return {16'd0, m_pre};
         3'd2: return m_mtime[31:0];
         3'd3: return m_shadow;
         3'd4: return m_cmp[31:0];
         3'd5: return m_cmp[63:32];
         3'd6: return {31'd0, m_match};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                             input logic [3:0] ws, input logic r, input logic [31:0] ra);
      logic [2:0]  sw, sr;
      logic        tick, ge;
      logic [63:0] nm;
      int          off;
      sw   = wa[4:2];
      sr   = ra[4:2];
      tick = m_en && (m_pcnt == 32'(m_pre));
      ge   = (m_mtime >= m_cmp);
      m_wready = w;
      m_rvalid = r;
      m_irq    = m_match && m_ie;
      if (r) begin
         m_rdata = mreg(sr);
         if (sr == 3'd2) m_shadow = m_mtime[63:32];
      end
      nm = m_mtime;
      if (w && (sw == 3'd2 || sw == 3'd3)) begin
         off = (sw == 3'd3) ? 32 : 0;
         for (int i = 0; i < 4; i++) if (ws[i]) nm[off + 8*i +: 8] = wd[8*i +: 8];
      end else if (tick) begin
         nm = (m_reload && ge) ? 64'd0 : m_mtime + 64'd1;
      end
      if (w && sw == 3'd6 && ws[0] && wd[0]) m_match = 1'b0;
      if (tick && ge) m_match = 1'b1;
      if ((w && sw == 3'd1) || !m_en || tick) m_pcnt = 0;
      else m_pcnt = m_pcnt + 1;
      m_mtime = nm;
      if (w && sw == 3'd0 && ws[0]) {m_ie, m_reload, m_en} = wd[2:0];
      if (w && sw == 3'd1) begin
         if (ws[0]) m_pre[7:0]  = wd[7:0];
         if (ws[1]) m_pre[15:8] = wd[15:8];
      end
      if (w && (sw == 3'd4 || sw == 3'd5)) begin
         off = (sw == 3'd5) ? 32 : 0;
         for (int i = 0; i < 4; i++) if (ws[i]) m_cmp[off + 8*i +: 8] = wd[8*i +: 8];
      end
   endtask

   task automatic cyc(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic r, input logic [31:0] ra);
      wen = w; waddr = wa; wdata = wd; wstrb = ws; ren = r; raddr = ra;
      model_step(w, wa, wd, ws, r, ra);
      @(posedge clk);
      #1;
      wen = 1'b0; ren = 1'b0;
   endtask

   task automatic wr(input logic [2:0] s, input logic [31:0] d);
      cyc(1'b1, {27'd0, s, 2'b00}, d, 4'hF, 1'b0, 32'd0);
   endtask

   task automatic rd(input logic [2:0] s);
      cyc(1'b0, 32'd0, 32'd0, 4'h0, 1'b1, {27'd0, s, 2'b00});
   endtask

   task automatic idle();
      cyc(1'b0, 32'd0, 32'd0, 4'h0, 1'b0, 32'd0);
   endtask

   task automatic test_reset();
      logic [31:0] exp_rst [0:7];
      exp_rst[0] = 32'd0; exp_rst[1] = 32'd0; exp_rst[2] = 32'd0; exp_rst[3] = 32'd0;
      exp_rst[4] = 32'hFFFF_FFFF; exp_rst[5] = 32'hFFFF_FFFF; exp_rst[6] = 32'd0; exp_rst[7] = 32'd0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({wready, rvalid, irq, rdata} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got %h expected 0", {wready, rvalid, irq, rdata});
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd(3'(i));
         n_checks++;
         if (rvalid !== 1'b1 || rdata !== exp_rst[i]) begin
            n_fail++;
            $display("FAIL reset_read[%0d] got v=%b d=%h expected v=1 d=%h", i, rvalid, rdata, exp_rst[i]);
         end
         idle();
         n_checks++;
         if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rvalid_drop[%0d] got %b expected 0", i, rvalid);
         end
      end
   endtask

   task automatic test_count_match();
      wr(3'd1, 32'd3); wr(3'd4, 32'd5); wr(3'd5, 32'd0); wr(3'd0, 32'h5);
      for (int c = 0; c < 40; c++) begin
         rd(3'd2);
         n_checks++;
         if (rdata !== m_rdata || irq !== m_irq) begin
            n_fail++;
            $display("FAIL count_match cyc %0d got d=%h irq=%b expected d=%h irq=%b", c, rdata, irq, m_rdata, m_irq);
         end
      end
      n_checks++;
      if (irq !== 1'b1 || m_mtime < 64'd6) begin
         n_fail++;
         $display("FAIL count_irq_set got irq=%b mtime=%0d expected irq=1 mtime>=6", irq, m_mtime);
      end
      for (int c = 0; c < 8 && m_pcnt != 0; c++) idle();
      wr(3'd6, 32'd1);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c_irq_lag got %b expected 1", irq);
      end
      idle();
      n_checks++;
      if (irq !== 1'b0 || irq !== m_irq) begin
         n_fail++;
         $display("FAIL w1c_irq_drop got %b expected 0", irq);
      end
   endtask

   task automatic test_reload();
      wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd4, 32'd2); wr(3'd5, 32'd0);
      wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd6, 32'd1); wr(3'd0, 32'h3);
      for (int c = 0; c < 12; c++) begin
         rd(3'd2);
         n_checks++;
         if (rdata !== m_rdata || rdata > 32'd2) begin
            n_fail++;
            $display("FAIL reload_seq cyc %0d got %h expected %h", c, rdata, m_rdata);
         end
      end
      for (int c = 0; c < 5 && m_mtime != 64'd2; c++) idle();
      wr(3'd6, 32'd1);
      rd(3'd6);
      n_checks++;
      if (rdata !== 32'd1) begin
         n_fail++;
         $display("FAIL reload_set_wins got %h expected 00000001", rdata);
      end
   endtask

   task automatic test_atomic();
      wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd2, 32'hFFFF_FFFF); wr(3'd3, 32'd0); wr(3'd0, 32'h1);
      idle(); idle();
      rd(3'd2);
      n_checks++;
      if (rdata !== m_rdata || rdata > 32'd4) begin
         n_fail++;
         $display("FAIL atomic_lo got %h expected %h", rdata, m_rdata);
      end
      idle(); idle(); idle();
      rd(3'd3);
      n_checks++;
      if (rdata !== 32'd1) begin
         n_fail++;
         $display("FAIL atomic_hi got %h expected 00000001", rdata);
      end
   endtask

   task automatic test_strobe();
      wr(3'd0, 32'd0);
      wr(3'd4, 32'hFFFF_FFFF);
      cyc(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'd0);
      n_checks++;
      if (wready !== 1'b1) begin
         n_fail++;
         $display("FAIL strobe_wready got %b expected 1", wready);
      end
      idle();
      n_checks++;
      if (wready !== 1'b0) begin
         n_fail++;
         $display("FAIL strobe_wready_drop got %b expected 0", wready);
      end
      rd(3'd4);
      n_checks++;
      if (rdata !== 32'hFFBB_FFDD) begin
         n_fail++;
         $display("FAIL strobe_cmp_lo got %h expected ffbbffdd", rdata);
      end
   endtask

   task automatic test_random();
      logic        w, r;
      logic [2:0]  s;
      logic [31:0] wa, wd, ra;
      for (int c = 0; c < 600; c++) begin
         w  = ($urandom_range(0, 2) == 0);
         r  = ($urandom_range(0, 1) == 0);
         s  = 3'($urandom_range(0, 7));
         wa = {4'h0, 23'($urandom), s, 2'($urandom)};
         ra = {4'h0, 23'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
         case (s)
            3'd1:       wd = 32'($urandom_range(0, 3));
            3'd2, 3'd4: wd = 32'($urandom_range(0, 40));
            3'd3, 3'd5: wd = 32'($urandom_range(0, 1));
            default:    wd = $urandom;
         endcase
         cyc(w, wa, wd, 4'($urandom), r, ra);
         n_checks++;
         if (rvalid !== m_rvalid || wready !== m_wready || irq !== m_irq || rdata !== m_rdata) begin
            n_fail++;
            $display("FAIL random cyc %0d got v=%b wr=%b irq=%b d=%h expected v=%b wr=%b irq=%b d=%h",
                     c, rvalid, wready, irq, rdata, m_rvalid, m_wready, m_irq, m_rdata);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_v;
      wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd4, 32'd0); wr(3'd5, 32'd0); wr(3'd0, 32'h5);
      idle(); idle(); idle();
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre_irq got %b expected 1", irq);
      end
      ren = 1'b1; raddr = 32'h0000_0008;
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if (rvalid !== 1'b0 || irq !== 1'b0 || rdata !== 32'd0 || wready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_immediate got v=%b irq=%b d=%h expected 0", rvalid, irq, rdata);
      end
      @(posedge clk);
      #1;
      ren = 1'b0;
      n_checks++;
      if (rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_rvalid got %b expected 0", rvalid);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         rd(3'(i));
         exp_v = (i == 4 || i == 5) ? 32'hFFFF_FFFF : 32'd0;
         n_checks++;
         if (rdata !== exp_v || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_reg[%0d] got d=%h irq=%b expected d=%h irq=0", i, rdata, irq, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_match();
      test_reload();
      test_atomic();
      test_strobe();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
